// File: rtl/pipelined_adder_sub.sv
// rtl/pipelined_adder_sub.sv - pipelined WIDTH-bit adder/subtractor with registered inter-segment carries
module pipelined_adder_sub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             sub,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             negative,
  output logic             zero,
  output logic             out_valid
);
  localparam int SEG = WIDTH / STAGES;

  // Each pipeline slot carries the full operands (skew for the upper segments),
  // the partial sum built so far (delay for the completed lower segments), its
  // own carry and its valid bit.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic             c_in;
    logic             v_in;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;
    logic [SEG:0]     seg_sum;
    logic [WIDTH-1:0] s_next;

    if (k == 0) begin : g_entry
      // Subtraction is A + ~B + 1; the +1 replaces carry_in.
      assign a_in = A;
      assign b_in = sub ? ~B : B;
      assign s_in = '0;
      assign c_in = sub ? 1'b1 : carry_in;
      assign v_in = in_valid;
    end else begin : g_chain
      assign a_in = g_stage[k-1].a_q;
      assign b_in = g_stage[k-1].b_q;
      assign s_in = g_stage[k-1].s_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
    end

    assign seg_sum = {1'b0, a_in[k*SEG +: SEG]} + {1'b0, b_in[k*SEG +: SEG]}
                   + {{SEG{1'b0}}, c_in};

    // Splice this stage's segment into the partial sum passed down the pipe.
    always_comb begin
      s_next = s_in;
      s_next[k*SEG +: SEG] = seg_sum[SEG-1:0];
    end

    // Slot register: advances on every non-stalled edge, bubbles included.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
        c_q <= 1'b0;
        v_q <= 1'b0;
      end else if (!stall) begin
        a_q <= a_in;
        b_q <= b_in;
        s_q <= s_next;
        c_q <= seg_sum[SEG];
        v_q <= v_in;
      end
    end
  end

  logic [WIDTH-1:0] fin_sum;
  logic             fin_carry;
  logic             fin_valid;
  logic             fin_a_msb;
  logic             fin_b_msb;
  logic             unused_ops;

  assign fin_sum   = g_stage[STAGES-1].s_q;
  assign fin_carry = g_stage[STAGES-1].c_q;
  assign fin_valid = g_stage[STAGES-1].v_q;
  assign fin_a_msb = g_stage[STAGES-1].a_q[WIDTH-1];
  assign fin_b_msb = g_stage[STAGES-1].b_q[WIDTH-1];
  // Only the operand sign bits matter once every segment has been summed.
  assign unused_ops = ^{g_stage[STAGES-1].a_q, g_stage[STAGES-1].b_q};

  // Output rank: loads result and flags only for completed valid ops, so the
  // last valid result stays visible across bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        result    <= fin_sum;
        carry_out <= fin_carry;
        // Same-signed operands (B already inverted for sub) with a
        // different-signed sum is exactly carry-into-MSB XOR carry-out.
        overflow  <= (fin_a_msb == fin_b_msb) && (fin_sum[WIDTH-1] != fin_a_msb);
        negative  <= fin_sum[WIDTH-1];
        zero      <= (fin_sum == '0);
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder_sub.sv
// tb/tb_pipelined_adder_sub.sv - scoreboard bench for pipelined_adder_sub at STAGES 4, 1 and 64
module tb_pipelined_adder_sub;
  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
    int          adv;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        sub = 1'b0;
  logic        carry_in = 1'b0;
  logic [63:0] A = '0;
  logic [63:0] B = '0;

  logic [63:0] res [3];
  logic        co [3];
  logic        ov [3];
  logic        ng [3];
  logic        zr [3];
  logic        ovld [3];

  int passed = 0;
  int total = 0;
  int adv = 0;

  always #5 clk = ~clk;

  pipelined_adder_sub #(.WIDTH(64), .STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .sub(sub),
    .carry_in(carry_in), .A(A), .B(B), .result(res[0]), .carry_out(co[0]),
    .overflow(ov[0]), .negative(ng[0]), .zero(zr[0]), .out_valid(ovld[0]));

  pipelined_adder_sub #(.WIDTH(64), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .sub(sub),
    .carry_in(carry_in), .A(A), .B(B), .result(res[1]), .carry_out(co[1]),
    .overflow(ov[1]), .negative(ng[1]), .zero(zr[1]), .out_valid(ovld[1]));

  pipelined_adder_sub #(.WIDTH(64), .STAGES(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .sub(sub),
    .carry_in(carry_in), .A(A), .B(B), .result(res[2]), .carry_out(co[2]),
    .overflow(ov[2]), .negative(ng[2]), .zero(zr[2]), .out_valid(ovld[2]));

  // Count of non-stalled edges; latency is measured in these.
  always @(posedge clk) if (!reset && !stall) adv <= adv + 1;

  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic ci);
    exp_t e;
    logic [63:0] bb;
    logic [64:0] t;
    bb = s ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {64'd0, (s ? 1'b1 : ci)};
    e.res = t[63:0];
    e.c = t[64];
    e.v = (a[63] == bb[63]) && (t[63] != a[63]);
    e.n = t[63];
    e.z = (t[63:0] == 64'd0);
    e.adv = 0;
    return e;
  endfunction

  // One scoreboard and monitor per instance; checks on each advancing edge.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : 64;
    exp_t q[$];
    int seen = 0;
    always @(negedge clk) begin
      exp_t e;
      if (!reset && adv != seen) begin
        seen = adv;
        if (ovld[g]) begin
          total++;
          if (q.size() == 0) begin
            $display("FAIL spurious_out inst=%0d got result=%h required no valid output", g, res[g]);
          end else begin
            e = q.pop_front();
            if (res[g] !== e.res || co[g] !== e.c || ov[g] !== e.v || ng[g] !== e.n ||
                zr[g] !== e.z || (adv - e.adv) != LAT + 1)
              $display("FAIL op_result inst=%0d got res=%h c=%b v=%b n=%b z=%b lat=%0d required res=%h c=%b v=%b n=%b z=%b lat=%0d",
                       g, res[g], co[g], ov[g], ng[g], zr[g], adv - e.adv - 1,
                       e.res, e.c, e.v, e.n, e.z, LAT);
            else passed++;
          end
        end else if (q.size() != 0 && (adv - q[0].adv) > LAT + 1) begin
          total++;
          $display("FAIL timeout inst=%0d got no output after %0d edges required latency %0d",
                   g, adv - q[0].adv - 1, LAT);
          e = q.pop_front();
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic [63:0] a,
                       input logic [63:0] b, input logic s, input logic ci);
    exp_t e;
    in_valid = v; stall = st; A = a; B = b; sub = s; carry_in = ci;
    if (v && !st) begin
      e = model(a, b, s, ci);
      e.adv = adv;
      g_mon[0].q.push_back(e);
      g_mon[1].q.push_back(e);
      g_mon[2].q.push_back(e);
    end
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        total++;
        if ({ovld[i], co[i], ov[i], ng[i], zr[i], res[i]} !== 69'd0)
          $display("FAIL reset_idle inst=%0d cycle=%0d got v=%b res=%h flags=%b%b%b%b required all zero",
                   i, c, ovld[i], res[i], co[i], ov[i], ng[i], zr[i]);
        else passed++;
      end
    end
  endtask

  task automatic test_carry_chain();
    drive(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    idle(3);
    total++;
    if (ovld[0] !== 1'b0) $display("FAIL carry_early got out_valid=%b required 0", ovld[0]);
    else passed++;
    idle(1);
    total++;
    if (ovld[0] !== 1'b1 || res[0] !== 64'd0 || co[0] !== 1'b1 || zr[0] !== 1'b1 ||
        ov[0] !== 1'b0 || ng[0] !== 1'b0)
      $display("FAIL carry_chain got v=%b res=%h c=%b z=%b v=%b n=%b required v=1 res=0 c=1 z=1 v=0 n=0",
               ovld[0], res[0], co[0], zr[0], ov[0], ng[0]);
    else passed++;
    idle(4);
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd5, 64'd7, 1'b1, 1'b1);
    idle(6);
  endtask

  task automatic test_back_to_back();
    logic [63:0] want [4];
    want[0] = 64'd2; want[1] = 64'd4; want[2] = 64'h1_0000_0000; want[3] = 64'd0;
    drive(1'b1, 1'b0, 64'd1, 64'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd2, 64'd2, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'd10, 64'd10, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      total++;
      if (ovld[0] !== 1'b1 || res[0] !== want[i])
        $display("FAIL back_to_back idx=%0d got v=%b res=%h required v=1 res=%h", i, ovld[0], res[0], want[i]);
      else passed++;
    end
    total++;
    if (zr[0] !== 1'b1 || co[0] !== 1'b1)
      $display("FAIL sub_equal_flags got z=%b c=%b required z=1 c=1", zr[0], co[0]);
    else passed++;
    idle(4);
  endtask

  task automatic test_stall();
    logic [68:0] snap [3];
    drive(1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) snap[i] = {ovld[i], co[i], ov[i], ng[i], zr[i], res[i]};
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 1'b1, 64'hDEAD_BEEF_0000_0000 + 64'(c), 64'd3, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
        total++;
        if ({ovld[i], co[i], ov[i], ng[i], zr[i], res[i]} !== snap[i])
          $display("FAIL stall_hold inst=%0d cycle=%0d got %h required %h", i, c,
                   {ovld[i], co[i], ov[i], ng[i], zr[i], res[i]}, snap[i]);
        else passed++;
      end
    end
    idle(2);
    total++;
    if (ovld[0] !== 1'b0) $display("FAIL stall_early got out_valid=%b required 0", ovld[0]);
    else passed++;
    idle(1);
    total++;
    if (ovld[0] !== 1'b1 || res[0] !== 64'h2222_2222_2222_2212)
      $display("FAIL stall_latency got v=%b res=%h required v=1 res=2222222222222212", ovld[0], res[0]);
    else passed++;
    idle(4);
  endtask

  task automatic test_random();
    logic [63:0] a;
    logic [63:0] b;
    for (int c = 0; c < 60; c++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: a = 64'hFFFF_FFFF_FFFF_FFFF;
        1: b = a;
        2: a = 64'h8000_0000_0000_0000;
        default: ;
      endcase
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), a, b,
            1'($urandom), 1'($urandom));
    end
    idle(70);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b0, 64'd100, 64'd23, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 64'hFFFF_0000_FFFF_0000, 64'h0001_0000_0001_0000, 1'b0, 1'b1);
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    g_mon[0].q.delete(); g_mon[1].q.delete(); g_mon[2].q.delete();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({ovld[i], co[i], ov[i], ng[i], zr[i], res[i]} !== 69'd0)
        $display("FAIL reset_async inst=%0d got v=%b res=%h required all zero", i, ovld[i], res[i]);
      else passed++;
    end
    step();
    reset = 1'b0;
    idle(70);
    drive(1'b1, 1'b0, 64'd7, 64'd9, 1'b1, 1'b0);
    idle(70);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (i == 0 && g_mon[0].q.size() != 0 || i == 1 && g_mon[1].q.size() != 0 ||
          i == 2 && g_mon[2].q.size() != 0)
        $display("FAIL drain inst=%0d got pending ops required none", i);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
